arp_tx: RTL and testbench

//  Transmit side of the board's ARP path. On a one-cycle start strobe it builds one complete ARP

---
 rtl/arp_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_arp_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_tx.sv
// ============================================================================
//  Module   : arp_tx
//  Purpose  : Builds one complete ARP Ethernet frame per start strobe and
//             drives it byte-serially onto the GMII TX bus. Layout on the
//             wire: preamble/SFD, Ethernet header, ARP body, zero pad, FCS.
//             The CRC-32 FCS is accumulated as the bytes are emitted.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arp_tx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd0, 8'd5},
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic        gmii_txc,
    input  logic        rst_n,
    input  logic        arp_tx_en,
    input  logic        arp_tx_type,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        tx_busy,
    output logic        tx_done
);

    // Byte positions are counted from the first preamble byte (0) through
    // the last FCS byte (71); the IFG continues the same count so that the
    // return to IDLE lands exactly 72 + IFG_BYTES cycles after the accept.
    localparam logic [15:0] c_first_ifg_idx = 16'd72;
    localparam logic [15:0] c_last_idx      = 16'(72 + IFG_BYTES);
    localparam logic [31:0] c_crc_init      = 32'hFFFF_FFFF;
    localparam logic [31:0] c_crc_poly      = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_ETH_HEAD = 3'd2,
        S_ARP_DATA = 3'd3,
        S_CRC      = 3'd4,
        S_IFG      = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_idx;      // position of the byte to be driven at the next edge
    logic [31:0] r_crc;
    logic        r_type;
    logic [47:0] r_mac;
    logic [31:0] r_ip;

    logic [6:0]  w_pos;
    logic [7:0]  w_byte;

    assign w_pos = r_idx[6:0];

    // Select one byte of a 48-bit MAC, byte 0 being the most significant.
    function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] k);
        logic [7:0] b;
        case (k)
            3'd0:    b = m[47:40];
            3'd1:    b = m[39:32];
            3'd2:    b = m[31:24];
            3'd3:    b = m[23:16];
            3'd4:    b = m[15:8];
            3'd5:    b = m[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Select one byte of a 32-bit IP, byte 0 being the most significant.
    function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = a[31:24];
            2'd1:    b = a[23:16];
            2'd2:    b = a[15:8];
            default: b = a[7:0];
        endcase
        return b;
    endfunction

    // Reflected CRC-32 advanced by one byte, data consumed LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            if (r[0]) r = (r >> 1) ^ c_crc_poly;
            else      r = r >> 1;
        end
        return r;
    endfunction

    // Frame byte for the current position, built from the latched request.
    always_comb begin
        w_byte = 8'h00;
        if (w_pos < 7'd7) begin
            w_byte = 8'h55;
        end else if (w_pos == 7'd7) begin
            w_byte = 8'hD5;
        end else if (w_pos < 7'd14) begin
            w_byte = r_type ? mac_byte(r_mac, 3'(w_pos - 7'd8)) : 8'hFF;
        end else if (w_pos < 7'd20) begin
            w_byte = mac_byte(BOARD_MAC, 3'(w_pos - 7'd14));
        end else if (w_pos < 7'd30) begin
            case (w_pos)
                7'd20:   w_byte = 8'h08;
                7'd21:   w_byte = 8'h06;
                7'd22:   w_byte = 8'h00;
                7'd23:   w_byte = 8'h01;
                7'd24:   w_byte = 8'h08;
                7'd25:   w_byte = 8'h00;
                7'd26:   w_byte = 8'h06;
                7'd27:   w_byte = 8'h04;
                7'd28:   w_byte = 8'h00;
                7'd29:   w_byte = {6'd0, r_type, ~r_type};
                default: w_byte = 8'h00;
            endcase
        end else if (w_pos < 7'd36) begin
            w_byte = mac_byte(BOARD_MAC, 3'(w_pos - 7'd30));
        end else if (w_pos < 7'd40) begin
            w_byte = ip_byte(BOARD_IP, 2'(w_pos - 7'd36));
        end else if (w_pos < 7'd46) begin
            w_byte = r_type ? mac_byte(r_mac, 3'(w_pos - 7'd40)) : 8'h00;
        end else if (w_pos < 7'd50) begin
            w_byte = ip_byte(r_ip, 2'(w_pos - 7'd46));
        end else if (w_pos < 7'd68) begin
            w_byte = 8'h00;
        end else if (w_pos < 7'd72) begin
            case (w_pos[1:0])
                2'd0:    w_byte = ~r_crc[7:0];
                2'd1:    w_byte = ~r_crc[15:8];
                2'd2:    w_byte = ~r_crc[23:16];
                default: w_byte = ~r_crc[31:24];
            endcase
        end
    end

    // Frame sequencer: one byte per cycle, CRC over header+body+pad, then IFG.
    always_ff @(posedge gmii_txc) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 16'd0;
            r_crc      <= c_crc_init;
            r_type     <= 1'b0;
            r_mac      <= 48'd0;
            r_ip       <= 32'd0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    tx_busy    <= 1'b0;
                    tx_done    <= 1'b0;
                    r_crc      <= c_crc_init;
                    r_idx      <= 16'd0;
                    if (arp_tx_en) begin
                        r_type     <= arp_tx_type;
                        r_mac      <= des_mac;
                        r_ip       <= des_ip;
                        gmii_tx_en <= 1'b1;
                        gmii_txd   <= 8'h55;
                        tx_busy    <= 1'b1;
                        r_idx      <= 16'd1;
                        r_state    <= S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    gmii_txd <= w_byte;
                    r_idx    <= r_idx + 16'd1;
                    if (w_pos == 7'd7) r_state <= S_ETH_HEAD;
                end
                S_ETH_HEAD: begin
                    gmii_txd <= w_byte;
                    r_crc    <= crc_next(r_crc, w_byte);
                    r_idx    <= r_idx + 16'd1;
                    if (w_pos == 7'd21) r_state <= S_ARP_DATA;
                end
                S_ARP_DATA: begin
                    gmii_txd <= w_byte;
                    r_crc    <= crc_next(r_crc, w_byte);
                    r_idx    <= r_idx + 16'd1;
                    if (w_pos == 7'd67) r_state <= S_CRC;
                end
                S_CRC: begin
                    // CRC register is frozen here; w_byte picks its inverted bytes.
                    gmii_txd <= w_byte;
                    r_idx    <= r_idx + 16'd1;
                    if (w_pos == 7'd71) r_state <= S_IFG;
                end
                S_IFG: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    tx_done    <= (r_idx == c_first_ifg_idx);
                    if (r_idx == c_last_idx) begin
                        tx_busy <= 1'b0;
                        r_idx   <= 16'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + 16'd1;
                    end
                end
                default: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    tx_busy    <= 1'b0;
                    tx_done    <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_arp_tx.sv
// ============================================================================
//  Module   : tb_arp_tx
//  Purpose  : Scoreboard bench for arp_tx. Stimulus pushes the expected frame
//             bytes into a queue; a monitor pops and compares every byte the
//             DUT presents, and checks tx_done, tx_busy length and FCS residue.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arp_tx;

    logic        clk;
    logic        rst_n;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        tx_busy;
    logic        tx_done;

    arp_tx dut (
        .gmii_txc    (clk),
        .rst_n       (rst_n),
        .arp_tx_en   (arp_tx_en),
        .arp_tx_type (arp_tx_type),
        .des_mac     (des_mac),
        .des_ip      (des_ip),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    int          expected_frames = 0;
    int          frames_seen = 0;
    bit          abort_pending = 0;
    int          rx_cnt = 0;
    logic [7:0]  rx_buf[72];
    logic [47:0] bmac = 48'h00_11_22_33_44_55;
    logic [31:0] bip  = 32'hC0_A8_00_05;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Expected frame, written out field by field.
    task automatic push_frame(input logic t, input logic [47:0] m, input logic [31:0] ip);
        logic [7:0]  f[72];
        logic [31:0] c;
        logic [31:0] fcs;
        for (int i = 0; i < 7; i++) f[i] = 8'h55;
        f[7] = 8'hD5;
        for (int i = 0; i < 6; i++) begin
            f[8 + i]  = t ? m[47 - 8*i -: 8] : 8'hFF;
            f[14 + i] = bmac[47 - 8*i -: 8];
            f[30 + i] = bmac[47 - 8*i -: 8];
            f[40 + i] = t ? m[47 - 8*i -: 8] : 8'h00;
        end
        f[20] = 8'h08; f[21] = 8'h06;
        f[22] = 8'h00; f[23] = 8'h01; f[24] = 8'h08; f[25] = 8'h00;
        f[26] = 8'h06; f[27] = 8'h04; f[28] = 8'h00; f[29] = t ? 8'h02 : 8'h01;
        for (int i = 0; i < 4; i++) begin
            f[36 + i] = bip[31 - 8*i -: 8];
            f[46 + i] = ip[31 - 8*i -: 8];
        end
        for (int i = 50; i < 68; i++) f[i] = 8'h00;
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < 68; i++) c = crc_upd(c, f[i]);
        fcs = ~c;
        f[68] = fcs[7:0]; f[69] = fcs[15:8]; f[70] = fcs[23:16]; f[71] = fcs[31:24];
        for (int i = 0; i < 72; i++) exp_q.push_back(f[i]);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic start(input logic t, input logic [47:0] m, input logic [31:0] ip);
        arp_tx_type = t;
        des_mac     = m;
        des_ip      = ip;
        arp_tx_en   = 1'b1;
        push_frame(t, m, ip);
        expected_frames++;
        @(posedge clk); #1;
        arp_tx_en = 1'b0;
    endtask

    task automatic pulse_ignored();
        arp_tx_en = 1'b1;
        @(posedge clk); #1;
        arp_tx_en = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (!tx_busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: timeout busy=%0b queued=%0d expected idle", tx_busy, exp_q.size());
        end
    endtask

    // Monitor: compares every presented byte and the framing side signals.
    bit prev_en   = 0;
    bit prev_busy = 0;
    int busy_cnt  = 0;
    always @(negedge clk) begin
        logic [31:0] res;
        logic [7:0]  e;
        if (gmii_tx_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %0h expected no transmission", gmii_txd);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("byte%0d", rx_cnt), {40'd0, gmii_txd}, {40'd0, e});
            end
            if (rx_cnt < 72) rx_buf[rx_cnt] = gmii_txd;
            rx_cnt++;
        end else begin
            check("txd_idle", {40'd0, gmii_txd}, 48'd0);
            if (prev_en) begin
                if (abort_pending) begin
                    check("abort_busy", {47'd0, tx_busy}, 48'd0);
                end else begin
                    check("frame_len", 48'(rx_cnt), 48'd72);
                    if (rx_cnt == 72) begin
                        res = 32'hFFFF_FFFF;
                        for (int i = 8; i < 72; i++) res = crc_upd(res, rx_buf[i]);
                        check("fcs_residue", {16'd0, res}, {16'd0, 32'hDEBB20E3});
                    end
                    frames_seen++;
                end
                rx_cnt = 0;
            end
        end
        check("tx_done", {47'd0, tx_done},
              {47'd0, (prev_en && !gmii_tx_en && !abort_pending)});
        if (tx_busy) begin
            busy_cnt++;
        end else if (prev_busy) begin
            if (!abort_pending) check("busy_len", 48'(busy_cnt), 48'd84);
            busy_cnt = 0;
        end
        if (prev_en && !gmii_tx_en) abort_pending = 0;
        prev_en   = gmii_tx_en;
        prev_busy = tx_busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n       = 1'b0;
        arp_tx_en   = 1'b0;
        arp_tx_type = 1'b0;
        des_mac     = 48'd0;
        des_ip      = 32'd0;
        repeat (3) @(posedge clk); #1;
        check("rst_tx_en", {47'd0, gmii_tx_en}, 48'd0);
        check("rst_txd",   {40'd0, gmii_txd},   48'd0);
        check("rst_busy",  {47'd0, tx_busy},    48'd0);
        check("rst_done",  {47'd0, tx_done},    48'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Reply frame
        start(1'b1, 48'h00_11_22_AA_BB_CC, {8'd192, 8'd168, 8'd0, 8'd2});
        check("start_en", {47'd0, gmii_tx_en}, 48'd1);
        check("start_busy", {47'd0, tx_busy}, 48'd1);
        wait_idle();

        // Request frame
        start(1'b0, 48'h0A_0B_0C_0D_0E_0F, {8'd192, 8'd168, 8'd0, 8'd9});
        wait_idle();

        // Start pulses mid-frame and mid-IFG are ignored; back-to-back accepted
        start(1'b1, 48'h66_55_44_33_22_11, {8'd10, 8'd0, 8'd0, 8'd16});
        repeat (20) @(posedge clk); #1;
        pulse_ignored();
        repeat (55) @(posedge clk); #1;
        check("ifg_en_low", {47'd0, gmii_tx_en}, 48'd0);
        pulse_ignored();
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (!tx_busy) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("busy_fall_seen", {47'd0, seen}, 48'd1);
        start(1'b0, 48'h12_34_56_78_9A_BC, {8'd192, 8'd168, 8'd1, 8'd1});
        check("b2b_en", {47'd0, gmii_tx_en}, 48'd1);
        check("b2b_txd", {40'd0, gmii_txd}, 48'h55);
        wait_idle();

        // Inputs change during a frame; latched values must be sent
        start(1'b1, 48'hDE_AD_BE_EF_00_01, {8'd172, 8'd16, 8'd5, 8'd7});
        repeat (10) @(posedge clk); #1;
        des_mac     = 48'hFF_EE_DD_CC_BB_AA;
        des_ip      = 32'h01020304;
        arp_tx_type = 1'b0;
        wait_idle();

        // Reset mid-frame aborts; next frame is complete
        start(1'b1, 48'h02_03_04_05_06_07, {8'd192, 8'd168, 8'd0, 8'd77});
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (rx_cnt >= 30) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reach_byte30", {47'd0, seen}, 48'd1);
        rst_n         = 1'b0;
        abort_pending = 1;
        @(posedge clk); #1;
        exp_q.delete();
        expected_frames--;
        check("abort_en",   {47'd0, gmii_tx_en}, 48'd0);
        check("abort_busy_now", {47'd0, tx_busy}, 48'd0);
        check("abort_done_now", {47'd0, tx_done}, 48'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        start(1'b0, 48'h00_00_00_00_00_00, {8'd192, 8'd168, 8'd0, 8'd200});
        wait_idle();

        repeat (5) @(posedge clk); #1;
        check("frames_seen", 48'(frames_seen), 48'(expected_frames));
        check("queue_empty", 48'(exp_q.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
